// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the system ID slave.
interface niosii_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// Reads the system ID and build timestamp words, compares them with build-time values and reports match/mismatch/timeout.
// Optional macro SYSID_CHECKER_AUTOSTART_EN: issue one implicit start right after reset release.
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1425246424,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    niosii_system_sysid_checker_if.master        avm,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 match,
    output logic                                 id_ok,
    output logic                                 ts_ok,
    output logic                                 timeout,
    output logic [31:0]                          captured_id,
    output logic [31:0]                          captured_ts
);

    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CHECK} state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic        start_eff;

`ifdef SYSID_CHECKER_AUTOSTART_EN
    logic auto_q;

    // Armed by reset, so it fires exactly once in the first cycle after release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) auto_q <= 1'b1;
        else       auto_q <= 1'b0;
    end

    assign start_eff = start | auto_q;
`else
    assign start_eff = start;
`endif

    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        match_d   = match_q;

        case (state_q)
            IDLE: begin
                if (start_eff) begin
                    state_d   = RD_ID;
                    stall_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            RD_ID: begin
                if (!avm.avm_waitrequest) begin
                    cap_id_d = avm.avm_readdata;
                    stall_d  = '0;
                    state_d  = RD_TS;
                end else if (stall_q == STALL_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = CHECK;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    cap_ts_d = avm.avm_readdata;
                    state_d  = CHECK;
                end else if (stall_q == STALL_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = CHECK;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            CHECK: begin
                id_ok_d = (cap_id_q == EXPECTED_ID) && !timeout_q;
                ts_ok_d = (cap_ts_q == EXPECTED_TIMESTAMP) && !timeout_q;
                match_d = id_ok_d && ts_ok_d;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are decoded from the next state so they come straight out of flops.
        read_d = (state_d == RD_ID) || (state_d == RD_TS);
        addr_d = (state_d == RD_TS);
        busy_d = (state_d != IDLE);
        done_d = (state_q == CHECK);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            stall_q   <= '0;
            read_q    <= 1'b0;
            addr_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= '0;
            cap_ts_q  <= '0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign match           = match_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout         = timeout_q;
    assign captured_id     = cap_id_q;
    assign captured_ts     = cap_ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Self-checking bench for niosii_system_sysid_checker: vector table, randomized runs and reset/autostart sequences.
module tb_niosii_system_sysid_checker;

    localparam int unsigned T      = 4;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1425246424;
    localparam int          NEVER  = 99;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, match, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;

    niosii_system_sysid_checker_if avm ();

    niosii_system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (T)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .avm         (avm),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout     (timeout),
        .captured_id (captured_id),
        .captured_ts (captured_ts)
    );

    always #5 clock = ~clock;

    // Slave: fixed words per address, stalls a programmable number of cycles per read.
    int          stall_id = 0, stall_ts = 0, scnt;
    logic [31:0] id_word = '0, ts_word = '0;

    assign avm.avm_readdata    = avm.avm_address ? ts_word : id_word;
    assign avm.avm_waitrequest = avm.avm_read && (scnt < (avm.avm_address ? stall_ts : stall_id));

    always @(posedge clock or posedge reset) begin
        if (reset)                                    scnt <= 0;
        else if (avm.avm_read && avm.avm_waitrequest) scnt <= scnt + 1;
        else                                          scnt <= 0;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: words last captured by the checker.
    logic [31:0] m_cap_id = '0, m_cap_ts = '0;

    task automatic run(input string tag, input int s_id, input int s_ts,
                       input logic [31:0] idw, input logic [31:0] tsw,
                       input int restart_at, input bit use_start, input bit has_exp,
                       input int x_done, input logic x_id_ok, input logic x_ts_ok, input logic x_to);
        int   rd_id, rd_ts, exp_done;
        logic to, e_id_ok, e_ts_ok;
        stall_id = s_id; stall_ts = s_ts; id_word = idw; ts_word = tsw;
        // A read survives at most T stalled cycles; one more stall aborts it.
        if (s_id > int'(T)) begin
            to = 1'b1; rd_id = T + 1; rd_ts = 0;
        end else begin
            rd_id = s_id + 1; m_cap_id = idw;
            if (s_ts > int'(T)) begin
                to = 1'b1; rd_ts = T + 1;
            end else begin
                to = 1'b0; rd_ts = s_ts + 1; m_cap_ts = tsw;
            end
        end
        exp_done = rd_id + rd_ts + 2;
        e_id_ok  = !to && (m_cap_id == EXP_ID);
        e_ts_ok  = !to && (m_cap_ts == EXP_TS);
        if (has_exp) begin
            exp_done = x_done; e_id_ok = x_id_ok; e_ts_ok = x_ts_ok; to = x_to;
        end
        if (use_start) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= exp_done; c++) begin
            if (c > 1) begin
                @(posedge clock); #1;
            end
            chk({tag, " read"}, 32'(avm.avm_read), 32'(c <= rd_id + rd_ts));
            if (c <= rd_id + rd_ts) chk({tag, " address"}, 32'(avm.avm_address), 32'(c > rd_id));
            chk({tag, " busy"}, 32'(busy), 32'(c < exp_done));
            chk({tag, " done"}, 32'(done), 32'(c == exp_done));
            start = (c == restart_at);
        end
        start = 1'b0;
        chk({tag, " timeout"}, 32'(timeout), 32'(to));
        chk({tag, " id_ok"}, 32'(id_ok), 32'(e_id_ok));
        chk({tag, " ts_ok"}, 32'(ts_ok), 32'(e_ts_ok));
        chk({tag, " match"}, 32'(match), 32'(e_id_ok && e_ts_ok));
        chk({tag, " captured_id"}, captured_id, m_cap_id);
        chk({tag, " captured_ts"}, captured_ts, m_cap_ts);
    endtask

    task automatic after_release(input string tag);
`ifdef SYSID_CHECKER_AUTOSTART_EN
        run({tag, " autostart"}, 0, 0, EXP_ID, EXP_TS, 0, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk({tag, " idle read"}, 32'(avm.avm_read), 32'd0);
            chk({tag, " idle done"}, 32'(done), 32'd0);
        end
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " read"}, 32'(avm.avm_read), 32'd0);
        chk({tag, " address"}, 32'(avm.avm_address), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " match"}, 32'(match), 32'd0);
        chk({tag, " id_ok"}, 32'(id_ok), 32'd0);
        chk({tag, " ts_ok"}, 32'(ts_ok), 32'd0);
        chk({tag, " timeout"}, 32'(timeout), 32'd0);
        chk({tag, " captured_id"}, captured_id, 32'd0);
        chk({tag, " captured_ts"}, captured_ts, 32'd0);
    endtask

    typedef struct {
        int          s_id;
        int          s_ts;
        logic [31:0] idw;
        logic [31:0] tsw;
        int          restart_at;
        int          x_done;
        logic        x_id_ok;
        logic        x_ts_ok;
        logic        x_to;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0,     0,     EXP_ID,        EXP_TS,        0, 4,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{0,     0,     EXP_ID,        EXP_TS + 1,    0, 4,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{0,     NEVER, EXP_ID,        EXP_TS,        0, 8,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{3,     3,     EXP_ID,        EXP_TS,        5, 10, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{5,     0,     EXP_ID,        EXP_TS,        0, 7,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{4,     4,     EXP_ID,        EXP_TS,        0, 12, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{0,     0,     32'd1,         EXP_TS,        0, 4,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{0,     0,     32'hFFFF_FFFF, 32'd0,         0, 4,  1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        after_release("init");

        for (int i = 0; i < 8; i++)
            run($sformatf("vec%0d", i), vecs[i].s_id, vecs[i].s_ts, vecs[i].idw, vecs[i].tsw,
                vecs[i].restart_at, 1'b1, 1'b1, vecs[i].x_done, vecs[i].x_id_ok,
                vecs[i].x_ts_ok, vecs[i].x_to);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] w_id, w_ts;
            w_id = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            w_ts = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            run($sformatf("rnd%0d", i), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                w_id, w_ts, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Abort a check in its second cycle; reset must drop the strobe at once.
        stall_id = 0; stall_ts = 0; id_word = EXP_ID; ts_word = EXP_TS;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("midreset pre read", 32'(avm.avm_read), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        m_cap_id = '0;
        m_cap_ts = '0;
        @(negedge clock);
        reset = 1'b0;
        after_release("midreset");
        run("post reset", 0, 0, EXP_ID, EXP_TS, 0, 1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
